bpug_ctrl: RTL

Sequencer for one BPUG binary processing-unit group. On a start pulse it streams weights and image bits from a 1-cycle-latency on-chip buffer, loads them, and issues compute/slide instructions for up to 10 vertical window positions at both column offsets. It drives the group's `data_in`, `instruction_in[9:0]` and `sel`, and flags when each `bpu_out` result is valid. The layer controller instantiates one per BPUG.

---
 rtl/bpug_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/bpug_ctrl.sv
// Sequencer for one BPUG: loads 56 weight + 16 image words, then issues CALC/UP per window row.
// Load instructions trail rd_en by one cycle; results flagged BPU_LAT after each CALC; no backpressure.
module bpug_ctrl #(
    parameter int          ADDR_W  = 12,
    parameter int          BPU_LAT = 2,
    parameter logic [4:0]  OP_NOP  = 5'd0,
    parameter logic [4:0]  OP_CALC = 5'd1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] wgt_base,
    input  logic [ADDR_W-1:0] img_base,
    input  logic [3:0]        n_rows,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [7:0]        data_out,
    output logic [9:0]        instr,
    output logic              sel,
    output logic              out_valid,
    output logic [3:0]        out_row,
    output logic              out_col
);

    typedef enum logic [2:0] {
        IDLE, LD_WGT, LD_IMG_LO, LD_IMG_HI, CALC0, CALC1, UP, DRAIN
    } state_t;

    state_t            state, state_d;
    logic [5:0]        cnt, cnt_d;
    logic [3:0]        row, row_d;
    logic [3:0]        nrows_q;
    logic [ADDR_W-1:0] wgt_q, img_q;
    logic [9:0]        ld_code, ld_instr_q, st_instr;
    logic              sel_q;
    logic              push, push_col;
    logic              pipe_busy;
    logic              pv [BPU_LAT];
    logic [3:0]        pr [BPU_LAT];
    logic              pc [BPU_LAT];
    logic [3:0]        n_eff;

    assign n_eff = (n_rows == 4'd0) ? 4'd1 : ((n_rows > 4'd10) ? 4'd10 : n_rows);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            row        <= '0;
            nrows_q    <= 4'd1;
            wgt_q      <= '0;
            img_q      <= '0;
            ld_instr_q <= '0;
            sel_q      <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            row        <= row_d;
            ld_instr_q <= ld_code;
            sel_q      <= rd_en;
            if (state == IDLE && start) begin
                wgt_q   <= wgt_base;
                img_q   <= img_base;
                nrows_q <= n_eff;
            end
        end
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        row_d    = row;
        rd_en    = 1'b0;
        rd_addr  = '0;
        ld_code  = '0;
        st_instr = {5'b0, OP_NOP};
        push     = 1'b0;
        push_col = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = LD_WGT;
                    cnt_d   = '0;
                    row_d   = '0;
                end
            end
            LD_WGT: begin
                rd_en   = 1'b1;
                rd_addr = wgt_q + ADDR_W'(cnt);
                ld_code = 10'h040;
                if (cnt == 6'd55) begin
                    state_d = LD_IMG_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 6'd1;
                end
            end
            LD_IMG_LO: begin
                rd_en   = 1'b1;
                rd_addr = img_q + ADDR_W'(cnt);
                ld_code = 10'h080;
                if (cnt == 6'd7) begin
                    state_d = LD_IMG_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 6'd1;
                end
            end
            LD_IMG_HI: begin
                // ninth cycle issues no read: it is the gap that lets the last load land
                if (cnt < 6'd8) begin
                    rd_en   = 1'b1;
                    rd_addr = img_q + ADDR_W'(cnt) + ADDR_W'(8);
                    ld_code = 10'h280;
                end
                if (cnt == 6'd8) begin
                    state_d = CALC0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 6'd1;
                end
            end
            CALC0: begin
                st_instr = {4'b0, 1'b0, OP_CALC};
                push     = 1'b1;
                push_col = 1'b0;
                state_d  = CALC1;
            end
            CALC1: begin
                st_instr = {4'b0, 1'b1, OP_CALC};
                push     = 1'b1;
                push_col = 1'b1;
                state_d  = (row < nrows_q - 4'd1) ? UP : DRAIN;
            end
            UP: begin
                st_instr = {1'b0, 1'b1, 3'b0, OP_NOP};
                row_d    = row + 4'd1;
                state_d  = CALC0;
            end
            DRAIN: begin
                if (!pipe_busy) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // result tracker mirrors the BPU compute latency
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < BPU_LAT; i++) begin
                pv[i] <= 1'b0;
                pr[i] <= '0;
                pc[i] <= 1'b0;
            end
        end else begin
            pv[0] <= push;
            pr[0] <= row;
            pc[0] <= push_col;
            for (int i = 1; i < BPU_LAT; i++) begin
                pv[i] <= pv[i-1];
                pr[i] <= pr[i-1];
                pc[i] <= pc[i-1];
            end
        end
    end

    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < BPU_LAT; i++) begin
            pipe_busy = pipe_busy | pv[i];
        end
    end

    assign busy      = (state != IDLE);
    assign data_out  = rd_data;
    assign instr     = sel_q ? ld_instr_q : st_instr;
    assign sel       = sel_q;
    assign out_valid = pv[BPU_LAT-1];
    assign out_row   = pr[BPU_LAT-1];
    assign out_col   = pc[BPU_LAT-1];

endmodule
